// File: rtl/nx_stream_pack_pkg.sv
// Shared widths, lane helpers and beat payload for the Nexus inbound stream packer.
package nx_stream_pkg;

    localparam int unsigned NX_MSG_WIDTH     = 31;
    localparam int unsigned NX_LANE_WIDTH    = 32;
    localparam int unsigned NX_LANE_CTRL_BIT = 31;
    localparam int unsigned NX_BEAT_WIDTH    = 2 * NX_LANE_WIDTH;
    localparam int unsigned NX_STRB_WIDTH    = NX_BEAT_WIDTH / 8;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_t;

    localparam logic [NX_STRB_WIDTH-1:0] STRB_LO   = 8'h0F;
    localparam logic [NX_STRB_WIDTH-1:0] STRB_FULL = 8'hFF;

    // One buffered output beat: strobes above data.
    typedef struct packed {
        logic [NX_STRB_WIDTH-1:0] strb;
        logic [NX_BEAT_WIDTH-1:0] data;
    } beat_t;

    function automatic logic [NX_LANE_WIDTH-1:0] mk_lane(input logic is_ctrl,
                                                         input logic [NX_MSG_WIDTH-1:0] payload);
        logic [NX_LANE_WIDTH-1:0] lane;
        lane = NX_LANE_WIDTH'(payload);
        lane[NX_LANE_CTRL_BIT] = is_ctrl;
        return lane;
    endfunction

endpackage

// File: rtl/nx_stream_pack_if.sv
// Host message inputs and AXI4-stream output of the stream packer.
interface nx_stream_pack_if #(
    parameter int unsigned AXI4_ID_WIDTH = 1
) ();

    logic [nx_stream_pkg::NX_MSG_WIDTH-1:0]  ctrl_ib_data;
    logic                                    ctrl_ib_valid;
    logic                                    ctrl_ib_ready;
    logic [nx_stream_pkg::NX_MSG_WIDTH-1:0]  mesh_ib_data;
    logic                                    mesh_ib_valid;
    logic                                    mesh_ib_ready;
    logic [nx_stream_pkg::NX_BEAT_WIDTH-1:0] stream_tdata;
    logic [nx_stream_pkg::NX_STRB_WIDTH-1:0] stream_tkeep;
    logic [nx_stream_pkg::NX_STRB_WIDTH-1:0] stream_tstrb;
    logic [AXI4_ID_WIDTH-1:0]                stream_tid;
    logic                                    stream_tlast;
    logic                                    stream_tvalid;
    logic                                    stream_tready;
    logic                                    status_busy;

    modport master (
        input  ctrl_ib_data, ctrl_ib_valid, mesh_ib_data, mesh_ib_valid, stream_tready,
        output ctrl_ib_ready, mesh_ib_ready,
        output stream_tdata, stream_tkeep, stream_tstrb, stream_tid, stream_tlast, stream_tvalid,
        output status_busy
    );

    modport slave (
        output ctrl_ib_data, ctrl_ib_valid, mesh_ib_data, mesh_ib_valid, stream_tready,
        input  ctrl_ib_ready, mesh_ib_ready,
        input  stream_tdata, stream_tkeep, stream_tstrb, stream_tid, stream_tlast, stream_tvalid,
        input  status_busy
    );

endinterface

// File: rtl/nx_fifo.sv
// Small synchronous FIFO with show-ahead head; push and pop may coincide.
module nx_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 72
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nx_stream_pack.sv
// Packs ctrl/mesh messages two per 64-bit AXI4-stream beat, low lane first.
// Define NX_PACK_TIMEOUT_EN to let a half-filled beat wait TIMEOUT idle cycles before flushing.
module nx_stream_pack
    import nx_stream_pkg::*;
#(
    parameter int unsigned AXI4_DATA_WIDTH = 64,
    parameter int unsigned AXI4_STRB_WIDTH = 8,
    parameter int unsigned AXI4_ID_WIDTH   = 1,
    parameter int unsigned TIMEOUT         = 16
) (
    input  logic             clk,
    input  logic             rstn,
    nx_stream_pack_if.master bus
);

    localparam int unsigned FIFO_W   = AXI4_DATA_WIDTH + AXI4_STRB_WIDTH;
    localparam logic [0:0]  ST_EMPTY = 1'(EMPTY);
    localparam logic [0:0]  ST_HALF  = 1'(HALF);

    logic [0:0]               state;
    logic [0:0]               state_nxt;
    logic [NX_LANE_WIDTH-1:0] lo_lane;
    logic [NX_LANE_WIDTH-1:0] lo_nxt;
    logic [NX_LANE_WIDTH-1:0] msg_lane;
    logic                     prio_ctrl;
    logic                     can_accept;
    logic                     grant_ctrl;
    logic                     grant_mesh;
    logic                     xfer;
    logic                     idle;
    logic                     flush;
    logic                     push;
    logic                     fifo_full;
    logic                     fifo_empty;
    beat_t                    push_beat;
    beat_t                    head_beat;
    logic [FIFO_W-1:0]        head_raw;

    // Round-robin grant; a held low lane only accepts its partner while the buffer has room.
    assign can_accept = rstn && ((state == ST_EMPTY) || !fifo_full);
    assign grant_ctrl = can_accept && bus.ctrl_ib_valid && (prio_ctrl || !bus.mesh_ib_valid);
    assign grant_mesh = can_accept && bus.mesh_ib_valid && !grant_ctrl;
    assign xfer       = grant_ctrl || grant_mesh;
    assign idle       = !bus.ctrl_ib_valid && !bus.mesh_ib_valid;
    assign msg_lane   = grant_ctrl ? mk_lane(1'b1, bus.ctrl_ib_data)
                                   : mk_lane(1'b0, bus.mesh_ib_data);

`ifdef NX_PACK_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;

    // Counts idle HALF cycles, saturating so a blocked flush still fires once room appears.
    always_comb begin
        timer_nxt = timer;
        if (state == ST_EMPTY) begin
            timer_nxt = '0;
        end else if (!xfer && (timer != TW'(TIMEOUT))) begin
            timer_nxt = timer + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) timer <= '0;
        else       timer <= timer_nxt;
    end

    assign flush = idle && (timer >= TW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign flush          = idle;
`endif

    always_comb begin
        state_nxt = state;
        lo_nxt    = lo_lane;
        push      = 1'b0;
        push_beat = '0;
        case (state)
            ST_EMPTY: begin
                if (xfer) begin
                    lo_nxt    = msg_lane;
                    state_nxt = ST_HALF;
                end
            end
            ST_HALF: begin
                if (xfer) begin
                    push           = 1'b1;
                    push_beat.strb = STRB_FULL;
                    push_beat.data = {msg_lane, lo_lane};
                    state_nxt      = ST_EMPTY;
                end else if (flush && !fifo_full) begin
                    push           = 1'b1;
                    push_beat.strb = STRB_LO;
                    push_beat.data = {NX_LANE_WIDTH'(0), lo_lane};
                    state_nxt      = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_EMPTY;
            lo_lane   <= '0;
            prio_ctrl <= 1'b1;
        end else begin
            state   <= state_nxt;
            lo_lane <= lo_nxt;
            if (xfer) prio_ctrl <= grant_mesh;
        end
    end

    nx_fifo #(
        .DEPTH (2),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (FIFO_W'(push_beat)),
        .pop       (bus.stream_tready),
        .pop_data  (head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_beat         = beat_t'(head_raw);
    assign bus.stream_tdata  = head_beat.data;
    assign bus.stream_tstrb  = head_beat.strb;
    assign bus.stream_tkeep  = head_beat.strb;
    assign bus.stream_tid    = AXI4_ID_WIDTH'(0);
    assign bus.stream_tlast  = 1'b1;
    assign bus.stream_tvalid = !fifo_empty;
    assign bus.status_busy   = (state == ST_HALF) || !fifo_empty;
    assign bus.ctrl_ib_ready = grant_ctrl;
    assign bus.mesh_ib_ready = grant_mesh;

endmodule

// File: tb/tb_nx_stream_pack.sv
// Directed and random checks of nx_stream_pack with a lane-unpacking scoreboard.
module tb_nx_stream_pack;

    localparam int unsigned TIMEOUT = 16;
`ifdef NX_PACK_TIMEOUT_EN
    localparam int LONE_LAT = TIMEOUT + 1;
`else
    localparam int LONE_LAT = 2;
`endif

    logic clk = 1'b0;
    logic rstn;
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] exp_q[$];
    logic        hold_prev;
    logic [63:0] data_prev;

    nx_stream_pack_if bus ();

    nx_stream_pack #(.TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.ctrl_ib_valid = 1'b0;
        bus.mesh_ib_valid = 1'b0;
        bus.stream_tready = 1'b1;
        repeat (2) cyc();
        rstn = 1'b1;
    endtask

    function automatic logic [30:0] cval(input int i);
        return 31'(32'h0100_0000 + i);
    endfunction

    function automatic logic [30:0] mval(input int i);
        return 31'(32'h0020_0000 + i);
    endfunction

    // Presents ctrl/mesh message ci/mi for one cycle and advances whichever was accepted.
    task automatic src_step(input bit en_c, input bit en_m, inout int ci, inout int mi,
                            output bit got_c, output bit got_m);
        bus.ctrl_ib_valid = en_c;
        bus.ctrl_ib_data  = cval(ci);
        bus.mesh_ib_valid = en_m;
        bus.mesh_ib_data  = mval(mi);
        #1;
        got_c = en_c && bus.ctrl_ib_ready;
        got_m = en_m && bus.mesh_ib_ready;
        cyc();
        if (got_c) ci++;
        if (got_m) mi++;
    endtask

    // Scoreboard: inputs in grant order, unpacked from each accepted beat low lane first.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            hold_prev <= 1'b0;
        end else begin
            if (hold_prev) chk("hold_stable", bus.stream_tdata, data_prev);
            chk("one_grant", 64'(bus.ctrl_ib_ready & bus.mesh_ib_ready), 64'd0);
            if (bus.stream_tvalid) begin
                chk("keep_eq_strb", 64'(bus.stream_tkeep), 64'(bus.stream_tstrb));
                chk("lo_strb", 64'(bus.stream_tstrb[3:0]), 64'hF);
                if (bus.stream_tready) begin
                    chk("sb_avail_lo", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) chk("sb_lo", 64'(bus.stream_tdata[31:0]), 64'(exp_q.pop_front()));
                    if (bus.stream_tstrb[7:4] == 4'hF) begin
                        chk("sb_avail_hi", 64'(exp_q.size() != 0), 64'd1);
                        if (exp_q.size() != 0) chk("sb_hi", 64'(bus.stream_tdata[63:32]), 64'(exp_q.pop_front()));
                    end else begin
                        chk("hi_strb", 64'(bus.stream_tstrb[7:4]), 64'd0);
                        chk("hi_zero", 64'(bus.stream_tdata[63:32]), 64'd0);
                    end
                end
            end
            if (bus.ctrl_ib_valid && bus.ctrl_ib_ready) exp_q.push_back({1'b1, bus.ctrl_ib_data});
            if (bus.mesh_ib_valid && bus.mesh_ib_ready) exp_q.push_back({1'b0, bus.mesh_ib_data});
            hold_prev <= bus.stream_tvalid && !bus.stream_tready;
            data_prev <= bus.stream_tdata;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  ci;
        int  mi;
        int  acc;
        bit  gc;
        bit  gm;

        rstn = 1'b0;
        bus.ctrl_ib_data  = '0;
        bus.ctrl_ib_valid = 1'b0;
        bus.mesh_ib_data  = '0;
        bus.mesh_ib_valid = 1'b0;
        bus.stream_tready = 1'b1;
        repeat (3) cyc();

        // Reset state, with both inputs requesting
        bus.ctrl_ib_valid = 1'b1;
        bus.mesh_ib_valid = 1'b1;
        #1;
        chk("rst_tvalid", 64'(bus.stream_tvalid), 64'd0);
        chk("rst_tdata", bus.stream_tdata, 64'd0);
        chk("rst_tstrb", 64'(bus.stream_tstrb), 64'd0);
        chk("rst_tkeep", 64'(bus.stream_tkeep), 64'd0);
        chk("rst_busy", 64'(bus.status_busy), 64'd0);
        chk("rst_cready", 64'(bus.ctrl_ib_ready), 64'd0);
        chk("rst_mready", 64'(bus.mesh_ib_ready), 64'd0);
        bus.ctrl_ib_valid = 1'b0;
        bus.mesh_ib_valid = 1'b0;
        cyc();
        rstn = 1'b1;
        cyc();
        chk("tlast", 64'(bus.stream_tlast), 64'd1);
        chk("tid", 64'(bus.stream_tid), 64'd0);

        // Lone ctrl message flushes as a low-lane-only beat
        bus.ctrl_ib_data  = 31'h1234567;
        bus.ctrl_ib_valid = 1'b1;
        #1;
        chk("t1_ready", 64'(bus.ctrl_ib_ready), 64'd1);
        cyc();
        bus.ctrl_ib_valid = 1'b0;
        chk("t1_busy", 64'(bus.status_busy), 64'd1);
        n = 1;
        while (!bus.stream_tvalid && n < 40) begin
            cyc();
            n++;
        end
        chk("t1_latency", 64'(n), 64'(LONE_LAT));
        chk("t1_tdata", bus.stream_tdata, 64'h0000_0000_8123_4567);
        chk("t1_tstrb", 64'(bus.stream_tstrb), 64'h0F);
        cyc();
        chk("t1_drained", 64'(bus.stream_tvalid), 64'd0);
        chk("t1_idle", 64'(bus.status_busy), 64'd0);

        // Mesh then ctrl back-to-back share one beat
        bus.mesh_ib_data  = 31'h1;
        bus.mesh_ib_valid = 1'b1;
        #1;
        chk("t2_mready", 64'(bus.mesh_ib_ready), 64'd1);
        cyc();
        bus.mesh_ib_valid = 1'b0;
        bus.ctrl_ib_data  = 31'h2;
        bus.ctrl_ib_valid = 1'b1;
        #1;
        chk("t2_cready", 64'(bus.ctrl_ib_ready), 64'd1);
        cyc();
        bus.ctrl_ib_valid = 1'b0;
        chk("t2_tvalid", 64'(bus.stream_tvalid), 64'd1);
        chk("t2_tdata", bus.stream_tdata, 64'h8000_0002_0000_0001);
        chk("t2_tstrb", 64'(bus.stream_tstrb), 64'hFF);
        cyc();

        // Both inputs valid: alternating grants starting with ctrl, beats {Mi, Ci}
        do_reset();
        ci = 0;
        mi = 0;
        for (int s = 0; s <= 8; s++) begin
            if (s >= 2 && (s % 2) == 0) begin
                chk("t3_tvalid", 64'(bus.stream_tvalid), 64'd1);
                chk("t3_beat", bus.stream_tdata, {1'b0, mval(s / 2 - 1), 1'b1, cval(s / 2 - 1)});
            end
            if (s < 8) begin
                bus.ctrl_ib_valid = (ci < 4);
                bus.ctrl_ib_data  = cval(ci);
                bus.mesh_ib_valid = (mi < 4);
                bus.mesh_ib_data  = mval(mi);
                #1;
                chk("t3_grant", 64'(bus.ctrl_ib_ready), 64'((s % 2) == 0));
                gc = bus.ctrl_ib_ready;
                gm = bus.mesh_ib_ready;
                cyc();
                if (gc) ci++;
                if (gm) mi++;
            end
            bus.ctrl_ib_valid = 1'b0;
            bus.mesh_ib_valid = 1'b0;
        end
        cyc();

        // Backpressure: two buffered beats plus a held lane, then inputs stall
        do_reset();
        bus.stream_tready = 1'b0;
        ci  = 0;
        mi  = 0;
        acc = 0;
        for (int s = 0; s < 10; s++) begin
            src_step(1'b1, 1'b1, ci, mi, gc, gm);
            acc += int'(gc) + int'(gm);
        end
        chk("t4_accepts", 64'(acc), 64'd5);
        #1;
        chk("t4_cready", 64'(bus.ctrl_ib_ready), 64'd0);
        chk("t4_mready", 64'(bus.mesh_ib_ready), 64'd0);
        chk("t4_busy", 64'(bus.status_busy), 64'd1);
        chk("t4_head", bus.stream_tdata, {1'b0, mval(0), 1'b1, cval(0)});
        bus.ctrl_ib_valid = 1'b0;
        bus.mesh_ib_valid = 1'b0;
        bus.stream_tready = 1'b1;
        n = 0;
        for (int s = 0; s < 40; s++) begin
            if (bus.stream_tvalid) n++;
            cyc();
        end
        chk("t4_beats", 64'(n), 64'd3);
        chk("t4_drained", 64'(bus.status_busy), 64'd0);

        // Reset while HALF with a full buffer
        do_reset();
        bus.stream_tready = 1'b0;
        ci = 0;
        mi = 0;
        for (int s = 0; s < 8; s++) src_step(1'b1, 1'b1, ci, mi, gc, gm);
        chk("t5_pre_busy", 64'(bus.status_busy), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_tvalid", 64'(bus.stream_tvalid), 64'd0);
        chk("t5_cready", 64'(bus.ctrl_ib_ready), 64'd0);
        chk("t5_mready", 64'(bus.mesh_ib_ready), 64'd0);
        chk("t5_busy", 64'(bus.status_busy), 64'd0);
        bus.ctrl_ib_valid = 1'b0;
        bus.mesh_ib_valid = 1'b0;
        repeat (2) cyc();
        rstn = 1'b1;
        bus.stream_tready = 1'b1;
        bus.mesh_ib_data  = 31'h0055_AA11;
        bus.mesh_ib_valid = 1'b1;
        cyc();
        bus.mesh_ib_valid = 1'b0;
        n = 1;
        while (!bus.stream_tvalid && n < 40) begin
            cyc();
            n++;
        end
        chk("t5_tdata", bus.stream_tdata, 64'h0000_0000_0055_AA11);
        chk("t5_tstrb", 64'(bus.stream_tstrb), 64'h0F);
        cyc();

        // Random traffic and backpressure, checked by the scoreboard
        do_reset();
        for (int s = 0; s < 10000; s++) begin
            if (!bus.ctrl_ib_valid && $urandom_range(0, 3) != 0) begin
                bus.ctrl_ib_valid = 1'b1;
                bus.ctrl_ib_data  = 31'($urandom);
            end
            if (!bus.mesh_ib_valid && $urandom_range(0, 3) != 0) begin
                bus.mesh_ib_valid = 1'b1;
                bus.mesh_ib_data  = 31'($urandom);
            end
            bus.stream_tready = ($urandom_range(0, 3) != 0);
            #1;
            gc = bus.ctrl_ib_valid && bus.ctrl_ib_ready;
            gm = bus.mesh_ib_valid && bus.mesh_ib_ready;
            cyc();
            if (gc) bus.ctrl_ib_valid = 1'b0;
            if (gm) bus.mesh_ib_valid = 1'b0;
        end
        bus.ctrl_ib_valid = 1'b0;
        bus.mesh_ib_valid = 1'b0;
        bus.stream_tready = 1'b1;
        n = 0;
        while (bus.status_busy && n < 60) begin
            cyc();
            n++;
        end
        cyc();
        chk("rand_idle", 64'(bus.status_busy), 64'd0);
        chk("rand_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
